// File: rtl/tick_scheduler.sv
// Programmable tick divider: emits one-cycle tick pulses for a bounded or unlimited run.
// Define TICK_SCHEDULER_SQUARE_EN to build the CLKout square-wave register.
module tick_scheduler #(
    parameter int unsigned DIV_W       = 32,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEFAULT_DIV = 25000000
) (
    input  logic             CLKin,
    input  logic             clr,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic             tick,
    output logic             CLKout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] ticks_left
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StPause = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] left_q, left_d;
    logic             xfer;
    logic             wrap;

    assign cfg_ready  = (state_q == StIdle) || (state_q == StDone);
    assign xfer       = cfg_valid && cfg_ready;
    assign wrap       = (cnt_q == (div_q - DIV_W'(1)));
    assign tick       = (state_q == StRun) && wrap;
    assign busy       = (state_q == StRun) || (state_q == StPause);
    assign done       = (state_q == StDone);
    assign ticks_left = left_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        count_d = count_q;
        left_d  = left_q;

        if (xfer) begin
            div_d   = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
            count_d = cfg_count;
        end

        if (stop) begin
            state_d = StIdle;
            cnt_d   = '0;
            left_d  = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d = StRun;
                        cnt_d   = '0;
                        // A same-cycle transfer takes effect for this run.
                        left_d  = xfer ? cfg_count : count_q;
                    end
                end
                StRun: begin
                    if (wrap) begin
                        cnt_d = '0;
                        if (count_q != '0) begin
                            left_d = left_q - CNT_W'(1);
                        end
                        // The final tick wins over a coincident pause.
                        if ((count_q != '0) && (left_q == CNT_W'(1))) begin
                            state_d = StDone;
                        end else if (pause) begin
                            state_d = StPause;
                        end
                    end else if (pause) begin
                        state_d = StPause;
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                StPause: begin
                    if (start && !pause) begin
                        state_d = StRun;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLKin or posedge clr) begin
        if (clr) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            div_q   <= DIV_W'(DEFAULT_DIV);
            count_q <= '0;
            left_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            count_q <= count_d;
            left_q  <= left_d;
        end
    end

`ifdef TICK_SCHEDULER_SQUARE_EN
    logic sq_q;

    always_ff @(posedge CLKin or posedge clr) begin
        if (clr) begin
            sq_q <= 1'b0;
        end else if (stop) begin
            sq_q <= 1'b0;
        end else if (tick) begin
            sq_q <= ~sq_q;
        end
    end

    assign CLKout = sq_q;
`else
    assign CLKout = 1'b0;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: directed runs push expected ticks, a monitor pops them.
module tb_tick_scheduler;

`ifdef TICK_SCHEDULER_SQUARE_EN
    localparam bit SqEn = 1'b1;
`else
    localparam bit SqEn = 1'b0;
`endif

    logic        CLKin;
    logic        clr;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_div;
    logic [15:0] cfg_count;
    logic        start;
    logic        pause;
    logic        stop;
    logic        tick;
    logic        CLKout;
    logic        busy;
    logic        done;
    logic [15:0] ticks_left;

    typedef struct {
        int unsigned cyc;
        int unsigned left;
        bit          sq;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc;
    int unsigned idx;
    int unsigned entry;
    int          n_checks;
    int          n_fail;

    tick_scheduler dut (
        .CLKin      (CLKin),
        .clr        (clr),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_div    (cfg_div),
        .cfg_count  (cfg_count),
        .start      (start),
        .pause      (pause),
        .stop       (stop),
        .tick       (tick),
        .CLKout     (CLKout),
        .busy       (busy),
        .done       (done),
        .ticks_left (ticks_left)
    );

    initial CLKin = 1'b0;
    always #5 CLKin = ~CLKin;

    initial cyc = 0;
    always @(posedge CLKin) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge CLKin);
        #1;
    endtask

    // Expected tick stream: n ticks, first at cycle 'first', spaced by 'period'.
    task automatic push_ticks(input int unsigned first, input int unsigned period,
                              input int unsigned n, input int unsigned left0);
        for (int i = 0; i < int'(n); i++) begin
            exp_t e;
            e.cyc  = first + i * period;
            e.left = (left0 == 0) ? 0 : left0 - i;
            e.sq   = SqEn ? idx[0] : 1'b0;
            idx++;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
        idx  = 0;
    endtask

    task automatic run_until_done(input string name, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (done) break;
            step();
        end
        check(name, done, 1);
    endtask

    task automatic wait_drain(input string name, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        check(name, exp_q.size(), 0);
    endtask

    always @(negedge CLKin) begin : monitor
        exp_t e;
        if (tick) begin
            if (exp_q.size() == 0) begin
                check("tick_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("tick_cycle", cyc, e.cyc);
                check("tick_left", ticks_left, e.left);
                check("tick_clkout", CLKout, e.sq);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        idx       = 0;
        clr       = 1'b1;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        cfg_count = '0;
        start     = 1'b0;
        pause     = 1'b0;
        stop      = 1'b0;
        #12;
        check("rst_tick", tick, 0);
        check("rst_clkout", CLKout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", cfg_ready, 1);
        check("rst_left", ticks_left, 0);
        check("rst_div", dut.div_q, 25000000);
        #5 clr = 1'b0;
        step();

        // div=4 count=3: ticks 4/8/12 cycles into the run, then DONE.
        cfg_valid = 1'b1; cfg_div = 32'd4; cfg_count = 16'd3;
        step();
        cfg_valid = 1'b0; start = 1'b1;
        step();
        start = 1'b0; entry = cyc;
        push_ticks(entry + 3, 4, 3, 3);
        check("s1_busy", busy, 1);
        check("s1_ready_run", cfg_ready, 0);
        run_until_done("s1_done", 30);
        check("s1_left_end", ticks_left, 0);
        check("s1_busy_end", busy, 0);
        repeat (6) step();
        check("s1_done_hold", done, 1);
        check("s1_drain", exp_q.size(), 0);

        // div=0 behaves as div=1: two back-to-back ticks.
        do_stop();
        check("stop_idle_done", done, 0);
        cfg_valid = 1'b1; cfg_div = 32'd0; cfg_count = 16'd2;
        step();
        cfg_valid = 1'b0; start = 1'b1;
        step();
        start = 1'b0; entry = cyc;
        push_ticks(entry, 1, 2, 2);
        run_until_done("s2_done", 10);
        check("s2_drain", exp_q.size(), 0);

        // Unlimited run with a 7-cycle pause at cnt=2; cfg and start in the same cycle.
        do_stop();
        cfg_valid = 1'b1; cfg_div = 32'd5; cfg_count = 16'd0; start = 1'b1;
        step();
        cfg_valid = 1'b0; start = 1'b0; entry = cyc;
        repeat (2) step();
        pause = 1'b1;
        repeat (7) step();
        check("s3_pause_busy", busy, 1);
        check("s3_pause_left", ticks_left, 0);
        pause = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        push_ticks(cyc + 2, 5, 4, 0);
        wait_drain("s3_drain", 40);
        check("s3_still_busy", busy, 1);
        check("s3_left_zero", ticks_left, 0);

        // stop beats start; div/count survive the stop.
        do_stop();
        cfg_valid = 1'b1; cfg_div = 32'd3; cfg_count = 16'd4;
        step();
        cfg_valid = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0; idx = 0;
        check("s4_ready", cfg_ready, 1);
        check("s4_busy", busy, 0);
        check("s4_left", ticks_left, 0);
        repeat (4) step();
        start = 1'b1;
        step();
        start = 1'b0; entry = cyc;
        push_ticks(entry + 2, 3, 4, 4);
        run_until_done("s4_done", 30);
        check("s4_drain", exp_q.size(), 0);

        // cfg offered during RUN is held off and accepted once DONE.
        do_stop();
        cfg_valid = 1'b1; cfg_div = 32'd2; cfg_count = 16'd2;
        step();
        cfg_valid = 1'b0; start = 1'b1;
        step();
        start = 1'b0; entry = cyc;
        push_ticks(entry + 1, 2, 2, 2);
        cfg_valid = 1'b1; cfg_div = 32'd7; cfg_count = 16'd1;
        check("s5_ready_run", cfg_ready, 0);
        run_until_done("s5_done", 20);
        check("s5_drain", exp_q.size(), 0);
        check("s5_ready_done", cfg_ready, 1);
        step();
        cfg_valid = 1'b0; start = 1'b1;
        step();
        start = 1'b0; entry = cyc;
        push_ticks(entry + 6, 7, 1, 1);
        run_until_done("s5_done2", 20);
        check("s5_drain2", exp_q.size(), 0);

        // Asynchronous clr mid-run, then restart.
        do_stop();
        cfg_valid = 1'b1; cfg_div = 32'd6; cfg_count = 16'd5;
        step();
        cfg_valid = 1'b0; start = 1'b1;
        step();
        start = 1'b0; entry = cyc;
        push_ticks(entry + 5, 6, 1, 5);
        repeat (7) step();
        check("s6_pre_clkout", CLKout, SqEn);
        #1 clr = 1'b1;
        #1;
        check("s6_clr_tick", tick, 0);
        check("s6_clr_busy", busy, 0);
        check("s6_clr_done", done, 0);
        check("s6_clr_ready", cfg_ready, 1);
        check("s6_clr_left", ticks_left, 0);
        check("s6_clr_clkout", CLKout, 0);
        check("s6_clr_div", dut.div_q, 25000000);
        #1 clr = 1'b0; idx = 0;
        step();
        check("s6_idle_after", busy, 0);
        cfg_valid = 1'b1; cfg_div = 32'd6; cfg_count = 16'd5; start = 1'b1;
        step();
        cfg_valid = 1'b0; start = 1'b0; entry = cyc;
        push_ticks(entry + 5, 6, 5, 5);
        run_until_done("s6_done", 60);
        check("final_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
